// File: rtl/sub_serial_if.sv
// Handshake and operand bus for the bit-serial operand-select subtractor.
interface sub_serial_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             s;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bo;

  modport master (output start, a, b, c, s, input busy, done, diff, bo);
  modport slave  (input start, a, b, c, s, output busy, done, diff, bo);
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: diff = s ? a - b : a - c, one bit per clock, LSB first.
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one difference bit per edge, WIDTH edges total
// FIN   | result registers hold the new value; done pulses for this cycle
module sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sub_serial_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rx;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic             bo_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             bit_a;
  logic             bit_x;
  logic             bit_d;
  logic             br_nxt;

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    bit_a  = ra[0];
    bit_x  = rx[0];
    bit_d  = bit_a ^ bit_x ^ br;
    br_nxt = (~bit_a & bit_x) | (~(bit_a ^ bit_x) & br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rx     <= '0;
      rd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra  <= bus.a;
            rx  <= bus.s ? bus.b : bus.c;
            rd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rx  <= rx >> 1;
          rd  <= {bit_d, rd[WIDTH-1:1]};
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          // The final bit goes straight into the result so partial values never show.
          if (last) begin
            diff_q <= {bit_d, rd[WIDTH-1:1]};
            bo_q   <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == FIN);
  assign bus.diff = diff_q;
  assign bus.bo   = bo_q;
endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial at WIDTH=4 and WIDTH=8 against a cycle-timeline reference model.
module tb_sub_serial;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sub_serial_if #(.WIDTH(4)) bus4 ();
  sub_serial_if #(.WIDTH(8)) bus8 ();

  sub_serial #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  sub_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: age = edges since the accepting edge, -1 when idle.
  int age[2]    = '{-1, -1};
  int m_diff[2] = '{0, 0};
  int m_bo[2]   = '{0, 0};
  int p_diff[2] = '{0, 0};
  int p_bo[2]   = '{0, 0};
  int ops[2]    = '{0, 0};

  function automatic int wsz(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  task automatic model_step(input int k, input bit st, input int a, input int b,
                            input int c, input bit s);
    int x;
    if (age[k] < 0) begin
      if (st) begin
        x         = s ? b : c;
        age[k]    = 0;
        p_diff[k] = (a - x) & ((1 << wsz(k)) - 1);
        p_bo[k]   = (a < x) ? 1 : 0;
        ops[k]++;
      end
    end else begin
      age[k]++;
      if (age[k] == wsz(k)) begin
        m_diff[k] = p_diff[k];
        m_bo[k]   = p_bo[k];
      end else if (age[k] == wsz(k) + 1) begin
        age[k] = -1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        age[k]    = -1;
        m_diff[k] = 0;
        m_bo[k]   = 0;
      end
    end else begin
      model_step(0, bus4.start, int'(bus4.a), int'(bus4.b), int'(bus4.c), bus4.s);
      model_step(1, bus8.start, int'(bus8.a), int'(bus8.b), int'(bus8.c), bus8.s);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy4", int'(bus4.busy), (age[0] >= 0) ? 1 : 0);
      check("done4", int'(bus4.done), (age[0] == 4) ? 1 : 0);
      check("diff4", int'(bus4.diff), m_diff[0]);
      check("bo4",   int'(bus4.bo),   m_bo[0]);
      check("busy8", int'(bus8.busy), (age[1] >= 0) ? 1 : 0);
      check("done8", int'(bus8.done), (age[1] == 8) ? 1 : 0);
      check("diff8", int'(bus8.diff), m_diff[1]);
      check("bo8",   int'(bus8.bo),   m_bo[1]);
    end
  end

  task automatic run_op4(input int a, input int b, input int c, input bit s,
                         input int pulse_at, input bit scramble,
                         output int d, output int bo, output int ndone, output int done_at);
    @(negedge clk);
    bus4.a = 4'(a); bus4.b = 4'(b); bus4.c = 4'(c); bus4.s = s;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    ndone = 0; d = -1; bo = -1; done_at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus4.done) begin
        ndone++;
        d       = int'(bus4.diff);
        bo      = int'(bus4.bo);
        done_at = i;
      end
      if (scramble) begin
        bus4.a = 4'($urandom_range(15));
        bus4.b = 4'($urandom_range(15));
        bus4.c = 4'($urandom_range(15));
        bus4.s = 1'($urandom_range(1));
      end
      bus4.start = (i == pulse_at);
    end
    bus4.start = 1'b0;
  endtask

  task automatic rand_run(input int k, input int target);
    for (int cyc = 0; cyc < 30000 && ops[k] < target; cyc++) begin
      @(negedge clk);
      if (k == 0) begin
        bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.c = 4'($urandom);
        bus4.s = 1'($urandom); bus4.start = 1'($urandom);
      end else begin
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.c = 8'($urandom);
        bus8.s = 1'($urandom); bus8.start = 1'($urandom);
      end
    end
    if (k == 0) bus4.start = 1'b0;
    else        bus8.start = 1'b0;
  endtask

  typedef struct {
    int a; int b; int c; bit s; int pulse; bit scr; int ed; int ebo;
  } vec_t;

  vec_t vt[7] = '{
    '{9,  3,  0, 1'b1, 0, 1'b1, 6,  0},
    '{3,  0,  5, 1'b0, 0, 1'b0, 14, 1},
    '{0,  15, 2, 1'b1, 0, 1'b0, 1,  1},
    '{15, 1,  15, 1'b0, 0, 1'b0, 0, 0},
    '{0,  0,  9, 1'b1, 0, 1'b0, 0,  0},
    '{12, 5,  1, 1'b1, 1, 1'b1, 7,  0},
    '{5,  2,  9, 1'b0, 4, 1'b0, 12, 1}
  };

  initial begin
    int d, bo, nd, dat, base4;
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c = '0; bus4.s = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c = '0; bus8.s = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus4.busy), 0);
    check("rst_done", int'(bus4.done), 0);
    check("rst_diff", int'(bus4.diff), 0);
    check("rst_bo",   int'(bus4.bo),   0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      run_op4(vt[i].a, vt[i].b, vt[i].c, vt[i].s, vt[i].pulse, vt[i].scr, d, bo, nd, dat);
      check($sformatf("vec%0d_diff", i),    d,   vt[i].ed);
      check($sformatf("vec%0d_bo", i),      bo,  vt[i].ebo);
      check($sformatf("vec%0d_ndone", i),   nd,  1);
      check($sformatf("vec%0d_done_at", i), dat, 4);
    end

    // START held high: back-to-back operations every 6 cycles.
    nd = 0;
    @(negedge clk);
    bus4.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus4.done) nd++;
      bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.c = 4'($urandom);
      bus4.s = 1'($urandom);
    end
    bus4.start = 1'b0;
    check("hold_ndone", nd, 5);
    repeat (8) @(negedge clk);

    // Asynchronous reset between edges clears outputs at once.
    run_op4(3, 0, 5, 1'b0, 0, 1'b0, d, bo, nd, dat);
    check("pre_rst_diff", d, 14);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", int'(bus4.busy), 0);
    check("async_done", int'(bus4.done), 0);
    check("async_diff", int'(bus4.diff), 0);
    check("async_bo",   int'(bus4.bo),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset after two bit edges abandons the operation.
    run_op4(3, 0, 5, 1'b0, 0, 1'b0, d, bo, nd, dat);
    check("pre_mid_bo", bo, 1);
    @(negedge clk);
    bus4.a = 4'd9; bus4.b = 4'd3; bus4.s = 1'b1; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", int'(bus4.busy), 0);
    check("mid_diff", int'(bus4.diff), 0);
    check("mid_bo",   int'(bus4.bo),   0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.done) nd++;
    end
    check("mid_no_done", nd, 0);
    check("mid_diff_after", int'(bus4.diff), 0);
    run_op4(7, 2, 0, 1'b1, 0, 1'b0, d, bo, nd, dat);
    check("post_rst_diff", d, 5);
    check("post_rst_bo",   bo, 0);
    check("post_rst_ndone", nd, 1);

    // Random operations on both widths in parallel.
    base4 = ops[0];
    fork
      rand_run(0, base4 + 1000);
      rand_run(1, 1000);
    join
    check("rand_ops4", (ops[0] >= base4 + 1000) ? 1 : 0, 1);
    check("rand_ops8", (ops[1] >= 1000) ? 1 : 0, 1);
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
